// File: rtl/qmac_array.sv
// Quantized multiply-accumulate array: LANES output channels share one u8 input stream,
// then bias, requantize (multiply, rounding shift, offset) and clamp. Build option: QMAC_ACC_SAT_EN.
module qmac_array #(
    parameter int LANES = 4,
    parameter int ACC_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  ivalid,
    input  logic                  ilast,
    input  logic [7:0]            in_d,
    input  logic [8*LANES-1:0]    fil_d,
    input  logic [32*LANES-1:0]   bias,
    input  logic [18*LANES-1:0]   out_mult,
    input  logic [5*LANES-1:0]    out_shift,
    input  logic [8:0]            in_offs,
    input  logic [8:0]            fil_offs,
    input  logic [8:0]            out_offs,
    input  logic [7:0]            actmin,
    input  logic [7:0]            actmax,
    output logic                  busy,
    output logic                  ovalid,
    input  logic                  oready,
    output logic [8*LANES-1:0]    accd,
    output logic [LANES-1:0]      ovf
);

    localparam int XW = ACC_W + 2;
    localparam int SW = 42;
    localparam int RW = XW + 2;
    localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SW-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [2:0] {IDLE, ACC, BIAS, MUL, RND, OUT} state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              clear;
    logic              accept;
    logic              beat_vld_reg;
    logic              beat_last_reg;
    logic signed [8:0] beat_in_reg;

    // Once the last beat is captured, further beats are refused until the tile finishes.
    assign clear  = (state_reg == IDLE) && start;
    assign accept = ivalid && (clear || ((state_reg == ACC) && !beat_last_reg));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            beat_vld_reg  <= 1'b0;
            beat_last_reg <= 1'b0;
            beat_in_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            beat_vld_reg  <= accept;
            beat_last_reg <= accept && ilast;
            if (accept) begin
                beat_in_reg <= {1'b0, in_d} + in_offs;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        ovalid     = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                if (beat_vld_reg && beat_last_reg) begin
                    state_next = BIAS;
                end
            end
            BIAS: state_next = MUL;
            MUL:  state_next = RND;
            RND:  state_next = OUT;
            OUT: begin
                ovalid = 1'b1;
                if (oready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [8:0]       fil_reg;
            logic signed [ACC_W-1:0] acc_reg;
            logic signed [ACC_W-1:0] acc_next;
            logic                    ovf_reg;
            logic                    ovf_hit;
            logic signed [17:0]      prod;
            logic signed [SW-1:0]    addend;
            logic signed [SW-1:0]    sum;
            logic signed [ACC_W+17:0] mprod;
            logic signed [XW-1:0]    xx_reg;
            logic signed [XW-1:0]    xx_next;
            logic [4:0]              sh;
            logic [63:0]             mask;
            logic [63:0]             rem;
            logic [63:0]             th;
            logic                    rnd_up;
            logic signed [XW-1:0]    shifted;
            logic signed [RW-1:0]    res;
            logic signed [RW-1:0]    lo;
            logic signed [RW-1:0]    hi;
            logic signed [RW-1:0]    clamped;
            logic [7:0]              accd_reg;
            logic [7:0]              accd_next;

            assign prod = fil_reg * beat_in_reg;

            // Sum is formed wide enough that overflow is a simple range test against ACC_W.
            always_comb begin
                addend = (state_reg == BIAS)
                       ? {{(SW-32){bias[32*gi+31]}}, bias[32*gi +: 32]}
                       : {{(SW-18){prod[17]}}, prod};
                sum     = {{(SW-ACC_W){acc_reg[ACC_W-1]}}, acc_reg} + addend;
                ovf_hit = (sum > ACC_MAX) || (sum < ACC_MIN);
`ifdef QMAC_ACC_SAT_EN
                if (ovf_hit) begin
                    acc_next = sum[SW-1] ? ACC_MIN[ACC_W-1:0] : ACC_MAX[ACC_W-1:0];
                end else begin
                    acc_next = sum[ACC_W-1:0];
                end
`else
                acc_next = sum[ACC_W-1:0];
`endif
            end

            assign mprod   = acc_reg * $signed(out_mult[18*gi +: 18]);
            assign xx_next = XW'(mprod >>> 16);

            // Round half away from zero: ties round up for positive and down for negative accumulators.
            always_comb begin
                sh      = out_shift[5*gi +: 5];
                mask    = (64'd1 << sh) - 64'd1;
                rem     = {{(64-XW){1'b0}}, xx_reg} & mask;
                th      = (mask >> 1) + {63'd0, acc_reg[ACC_W-1]};
                rnd_up  = rem > th;
                shifted = xx_reg >>> sh;
                res     = {{(RW-XW){shifted[XW-1]}}, shifted}
                        + {{(RW-9){out_offs[8]}}, out_offs}
                        + {{(RW-1){1'b0}}, rnd_up};
                lo      = {{(RW-8){1'b0}}, actmin};
                hi      = {{(RW-8){1'b0}}, actmax};
                if (res < lo) begin
                    clamped = lo;
                end else if (res > hi) begin
                    clamped = hi;
                end else begin
                    clamped = res;
                end
                accd_next = 8'(clamped);
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    fil_reg  <= '0;
                    acc_reg  <= '0;
                    ovf_reg  <= 1'b0;
                    xx_reg   <= '0;
                    accd_reg <= '0;
                end else begin
                    if (clear) begin
                        acc_reg <= '0;
                        ovf_reg <= 1'b0;
                    end else if (((state_reg == ACC) && beat_vld_reg) || (state_reg == BIAS)) begin
                        acc_reg <= acc_next;
                        if (ovf_hit) begin
                            ovf_reg <= 1'b1;
                        end
                    end
                    if (accept) begin
                        fil_reg <= {1'b0, fil_d[8*gi +: 8]} + fil_offs;
                    end
                    if (state_reg == MUL) begin
                        xx_reg <= xx_next;
                    end
                    if (state_reg == RND) begin
                        accd_reg <= accd_next;
                    end
                end
            end

            assign accd[8*gi +: 8] = accd_reg;
            assign ovf[gi]         = ovf_reg;
        end
    endgenerate

endmodule

// File: tb/tb_qmac_array.sv
// Scoreboard bench for qmac_array: a 32-bit and an 18-bit accumulator instance share all inputs.
module tb_qmac_array;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0, ivalid = 1'b0, ilast = 1'b0, oready = 1'b1;
    logic [7:0]   in_d = '0;
    logic [31:0]  fil_d = '0;
    logic [127:0] bias = '0;
    logic [71:0]  out_mult = '0;
    logic [19:0]  out_shift = '0;
    logic [8:0]   in_offs = '0, fil_offs = '0, out_offs = '0;
    logic [7:0]   actmin = '0, actmax = 8'd255;
    logic         busy_a, ovalid_a, busy_b, ovalid_b;
    logic [31:0]  accd_a, accd_b;
    logic [3:0]   ovf_a, ovf_b;

    qmac_array #(.LANES(4), .ACC_W(32)) dut_a (
        .clk(clk), .reset(reset), .start(start), .ivalid(ivalid), .ilast(ilast),
        .in_d(in_d), .fil_d(fil_d), .bias(bias), .out_mult(out_mult), .out_shift(out_shift),
        .in_offs(in_offs), .fil_offs(fil_offs), .out_offs(out_offs), .actmin(actmin), .actmax(actmax),
        .busy(busy_a), .ovalid(ovalid_a), .oready(oready), .accd(accd_a), .ovf(ovf_a));

    qmac_array #(.LANES(4), .ACC_W(18)) dut_b (
        .clk(clk), .reset(reset), .start(start), .ivalid(ivalid), .ilast(ilast),
        .in_d(in_d), .fil_d(fil_d), .bias(bias), .out_mult(out_mult), .out_shift(out_shift),
        .in_offs(in_offs), .fil_offs(fil_offs), .out_offs(out_offs), .actmin(actmin), .actmax(actmax),
        .busy(busy_b), .ovalid(ovalid_b), .oready(oready), .accd(accd_b), .ovf(ovf_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] accd_a;
        logic [3:0]  ovf_a;
        logic [31:0] accd_b;
        logic [3:0]  ovf_b;
        int          rise;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic ovalid_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: latency on the rising edge of ovalid, data on every ovalid&&oready transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("ovalid_a_vs_b", {63'd0, ovalid_b}, {63'd0, ovalid_a});
            if (ovalid_a && !ovalid_prev) begin
                if (sb.size() == 0) chk("spurious_ovalid", 64'd1, 64'd0);
                else                chk("ovalid_latency", 64'(cyc), 64'(sb[0].rise));
            end
            if (ovalid_a && oready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("accd_a", {32'd0, accd_a}, {32'd0, e.accd_a});
                    chk("ovf_a",  {60'd0, ovf_a},  {60'd0, e.ovf_a});
                    chk("accd_b", {32'd0, accd_b}, {32'd0, e.accd_b});
                    chk("ovf_b",  {60'd0, ovf_b},  {60'd0, e.ovf_b});
                    $display("tile out: accd_a=%h ovf_a=%h accd_b=%h ovf_b=%h", accd_a, ovf_a, accd_b, ovf_b);
                end
            end
        end
        ovalid_prev = ovalid_a;
    end

    task automatic set_fil(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        fil_d = {d, c, b, a};
    endtask

    task automatic set_bias(input int a, input int b, input int c, input int d);
        bias = {d, c, b, a};
    endtask

    task automatic set_basic();
        in_offs = '0; fil_offs = '0; out_offs = '0; actmin = 8'd0; actmax = 8'd255;
        in_d = 8'd2; set_fil(3, 3, 3, 3); set_bias(0, 0, 0, 0);
        out_mult = {4{18'd65536}}; out_shift = '0;
    endtask

    task automatic send_tile(input int n, input logic [31:0] ea, input logic [3:0] oa,
                             input logic [31:0] eb, input logic [3:0] ob);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = (i == 0); ivalid = 1'b1; ilast = (i == n - 1);
            if (i == n - 1) begin
                e.accd_a = ea; e.ovf_a = oa; e.accd_b = eb; e.ovf_b = ob;
                e.rise = cyc + 5;
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        start = 1'b0; ivalid = 1'b0; ilast = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while ((sb.size() != 0 || busy_a || busy_b) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("tile_completes_in_budget", {63'd0, (k >= 200)}, 64'd0);
        if (k >= 200) sb.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        int k;
        set_basic();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_a", {63'd0, busy_a}, 64'd0);
        chk("rst_ovalid_a", {63'd0, ovalid_a}, 64'd0);
        chk("rst_accd_a", {32'd0, accd_a}, 64'd0);
        chk("rst_ovf_b", {60'd0, ovf_b}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // basic: 4 beats of 2*3
        send_tile(4, {4{8'd24}}, 4'h0, {4{8'd24}}, 4'h0);
        wait_done();

        // per-lane filters: 2 beats of 5*{1,2,3,4}
        in_d = 8'd5; set_fil(1, 2, 3, 4);
        send_tile(2, {8'd40, 8'd30, 8'd20, 8'd10}, 4'h0, {8'd40, 8'd30, 8'd20, 8'd10}, 4'h0);
        wait_done();

        // offsets: (10-3)*({20,30,5,0}-25) + 200
        in_d = 8'd10; in_offs = 9'h1FD; fil_offs = 9'h1E7; set_fil(20, 30, 5, 0); set_bias(200, 200, 200, 200);
        send_tile(1, {8'd25, 8'd60, 8'd235, 8'd165}, 4'h0, {8'd25, 8'd60, 8'd235, 8'd165}, 4'h0);
        wait_done();

        // rounding: shift 2, out_offs 128, bias {6,-6,5,7}
        set_basic(); in_d = 8'd0; set_fil(0, 0, 0, 0);
        out_shift = {4{5'd2}}; out_offs = 9'd128; set_bias(6, -6, 5, 7);
        send_tile(1, {8'd130, 8'd129, 8'd126, 8'd130}, 4'h0, {8'd130, 8'd129, 8'd126, 8'd130}, 4'h0);
        wait_done();

        // clamp: actmax 200, bias {250,-5,100,300}
        out_shift = '0; out_offs = '0; actmax = 8'd200; set_bias(250, -5, 100, 300);
        send_tile(1, {8'd200, 8'd100, 8'd0, 8'd200}, 4'h0, {8'd200, 8'd100, 8'd0, 8'd200}, 4'h0);
        wait_done();

        // multiplier 0.5, out_offs 20, bias {10,11,-10,1000}
        actmax = 8'd255; out_mult = {4{18'd32768}}; out_offs = 9'd20; set_bias(10, 11, -10, 1000);
        send_tile(1, {8'd255, 8'd15, 8'd25, 8'd25}, 4'h0, {8'd255, 8'd15, 8'd25, 8'd25}, 4'h0);
        wait_done();

        // overflow: 3 beats of 255*255; 18-bit acc saturates to 131071 or wraps to -67069
        set_basic(); in_d = 8'd255; set_fil(255, 255, 255, 255);
        out_mult = {4{18'd1}}; out_offs = 9'd100;
`ifdef QMAC_ACC_SAT_EN
        send_tile(3, {4{8'd102}}, 4'h0, {4{8'd101}}, 4'hF);
`else
        send_tile(3, {4{8'd102}}, 4'h0, {4{8'd98}}, 4'hF);
`endif
        wait_done();

        // next start clears ovf
        set_basic();
        send_tile(4, {4{8'd24}}, 4'h0, {4{8'd24}}, 4'h0);
        wait_done();

        // backpressure: hold output 10 cycles while start pulses are ignored
        in_d = 8'd3;
        oready = 1'b0;
        send_tile(4, {4{8'd36}}, 4'h0, {4{8'd36}}, 4'h0);
        k = 0;
        while (!ovalid_a && k < 50) begin @(negedge clk); k++; end
        chk("bp_ovalid_seen", {63'd0, ovalid_a}, 64'd1);
        held = accd_a;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            start = (j % 2 == 0); ivalid = (j % 2 == 0);
            @(negedge clk);
            chk("bp_accd_stable", {32'd0, accd_a}, {32'd0, held});
            chk("bp_ovalid_held", {63'd0, ovalid_a}, 64'd1);
            chk("bp_busy", {63'd0, busy_a}, 64'd1);
        end
        @(posedge clk); #1;
        start = 1'b0; ivalid = 1'b0; oready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_after_xfer", {62'd0, busy_a, busy_b}, 64'd0);
        chk("bp_ovalid_fell", {63'd0, ovalid_a}, 64'd0);
        wait_done();

        // reset in the middle of an overflowing tile
        in_d = 8'd255; set_fil(255, 255, 255, 255);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = (i == 0); ivalid = 1'b1; ilast = 1'b0;
        end
        @(posedge clk); #1;
        start = 1'b0; ivalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_ovf_b_set", {60'd0, ovf_b}, 64'hF);
        chk("mid_busy", {63'd0, busy_a}, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {62'd0, busy_a, busy_b}, 64'd0);
        chk("mid_rst_ovalid", {62'd0, ovalid_a, ovalid_b}, 64'd0);
        chk("mid_rst_accd", {accd_a, accd_b}, 64'd0);
        chk("mid_rst_ovf", {56'd0, ovf_a, ovf_b}, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        set_basic();
        send_tile(4, {4{8'd24}}, 4'h0, {4{8'd24}}, 4'h0);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
